// File: rtl/mt_hazard_controller.sv
// Hazard and coarse-grained thread-scheduling controller for the multithreaded 5-stage pipeline.
// Define MT_HAZARD_STATS_EN to add the switch_count / idle_cycles statistics outputs.
module mt_hazard_controller #(
  parameter int THREADS        = 2,
  parameter int TID_W          = 1,
  parameter int SWITCH_PENALTY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ic_miss,
  input  logic             load_use,
  input  logic             mispredict,
  input  logic [TID_W-1:0] mispredict_tid,
  input  logic             dc_miss,
  input  logic [TID_W-1:0] dc_miss_tid,
  input  logic             dc_fill,
  input  logic [TID_W-1:0] dc_fill_tid,
  output logic             if_stall,
  output logic             if_flush,
  output logic             i2d_stall,
  output logic             i2d_flush,
  output logic             d2e_stall,
  output logic             d2e_flush,
  output logic             e2m_stall,
  output logic             e2m_flush,
  output logic             m2w_stall,
  output logic             m2w_flush,
  output logic [TID_W-1:0] fetch_tid,
  output logic             thread_switch,
  output logic             all_blocked
`ifdef MT_HAZARD_STATS_EN
  ,
  output logic [31:0]      switch_count,
  output logic [31:0]      idle_cycles
`endif
);

  typedef enum logic [1:0] {RUN, SWITCH, IDLE} state_t;

  state_t             state;
  logic [THREADS-1:0] blocked;
  logic [3:0]         cnt;

  logic               miss_ok, fill_ok, miss_cur;
  logic [THREADS-1:0] miss_mask, fill_mask, blocked_nxt;
  logic               nxt_found;
  logic [TID_W-1:0]   nxt_tid, cand;

  always_comb begin
    miss_ok     = dc_miss && (int'(dc_miss_tid) < THREADS);
    fill_ok     = dc_fill && (int'(dc_fill_tid) < THREADS);
    miss_mask   = miss_ok ? (THREADS'(1) << dc_miss_tid) : '0;
    fill_mask   = fill_ok ? (THREADS'(1) << dc_fill_tid) : '0;
    // a miss and a fill for the same thread leave it blocked
    blocked_nxt = (blocked & ~fill_mask) | miss_mask;
    miss_cur    = miss_ok && (dc_miss_tid == fetch_tid);
    nxt_found   = 1'b0;
    nxt_tid     = fetch_tid;
    cand        = fetch_tid;
    for (int k = 1; k < THREADS; k++) begin
      cand = TID_W'((int'(fetch_tid) + k) % THREADS);
      if (!nxt_found && !blocked_nxt[cand]) begin
        nxt_found = 1'b1;
        nxt_tid   = cand;
      end
    end
  end

  always_comb begin
    if_stall      = 1'b0;
    if_flush      = 1'b0;
    i2d_stall     = 1'b0;
    i2d_flush     = 1'b0;
    d2e_stall     = 1'b0;
    d2e_flush     = 1'b0;
    e2m_stall     = 1'b0;
    e2m_flush     = 1'b0;
    m2w_stall     = 1'b0;
    m2w_flush     = 1'b0;
    thread_switch = 1'b0;
    all_blocked   = 1'b0;
    if (!rst_n) begin
      if_flush  = 1'b1;
      i2d_flush = 1'b1;
      d2e_flush = 1'b1;
      e2m_flush = 1'b1;
      m2w_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (miss_cur) begin
            if_flush      = 1'b1;
            i2d_flush     = 1'b1;
            d2e_flush     = 1'b1;
            e2m_flush     = 1'b1;
            m2w_flush     = 1'b1;
            thread_switch = nxt_found;
          end else if (mispredict && (mispredict_tid == fetch_tid)) begin
            i2d_flush = 1'b1;
            d2e_flush = 1'b1;
          end else if (load_use) begin
            if_stall  = 1'b1;
            i2d_stall = 1'b1;
            d2e_flush = 1'b1;
          end else if (ic_miss) begin
            if_stall  = 1'b1;
            i2d_flush = 1'b1;
          end
        end
        SWITCH: begin
          if_stall  = 1'b1;
          i2d_flush = 1'b1;
        end
        IDLE: begin
          if_stall      = 1'b1;
          i2d_flush     = 1'b1;
          d2e_flush     = 1'b1;
          e2m_flush     = 1'b1;
          m2w_flush     = 1'b1;
          all_blocked   = 1'b1;
          thread_switch = fill_ok;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      blocked   <= '0;
      fetch_tid <= '0;
      cnt       <= '0;
    end else begin
      blocked <= blocked_nxt;
      case (state)
        RUN: begin
          if (miss_cur) begin
            if (nxt_found) begin
              fetch_tid <= nxt_tid;
              cnt       <= 4'(SWITCH_PENALTY);
              state     <= SWITCH;
            end else begin
              state <= IDLE;
            end
          end
        end
        SWITCH: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= RUN;
        end
        IDLE: begin
          if (fill_ok) begin
            fetch_tid <= dc_fill_tid;
            cnt       <= 4'(SWITCH_PENALTY);
            state     <= SWITCH;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef MT_HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      switch_count <= '0;
      idle_cycles  <= '0;
    end else begin
      if (thread_switch && (switch_count != '1)) switch_count <= switch_count + 32'd1;
      if ((state == IDLE) && (idle_cycles != '1)) idle_cycles <= idle_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mt_hazard_controller.sv
// Scoreboard bench for mt_hazard_controller: a cycle-level reference model queues the
// expected controls, and a monitor on the falling edge pops and compares them.
module tb_mt_hazard_controller;
  localparam int THREADS = 2;
  localparam int TID_W   = 1;
  localparam int PEN     = 2;

  // {if, i2d, d2e, e2m, m2w} x {stall, flush}
  localparam logic [9:0] C_NONE = 10'b00_00_00_00_00;
  localparam logic [9:0] C_ALLF = 10'b01_01_01_01_01;
  localparam logic [9:0] C_MP   = 10'b00_01_01_00_00;
  localparam logic [9:0] C_LU   = 10'b10_10_01_00_00;
  localparam logic [9:0] C_IC   = 10'b10_01_00_00_00;
  localparam logic [9:0] C_SW   = 10'b10_01_00_00_00;
  localparam logic [9:0] C_IDLE = 10'b10_01_01_01_01;

  logic clk = 0, rst_n = 0;
  logic ic_miss = 0, load_use = 0, mispredict = 0, dc_miss = 0, dc_fill = 0;
  logic [TID_W-1:0] mispredict_tid = '0, dc_miss_tid = '0, dc_fill_tid = '0;
  logic if_stall, if_flush, i2d_stall, i2d_flush, d2e_stall, d2e_flush;
  logic e2m_stall, e2m_flush, m2w_stall, m2w_flush, thread_switch, all_blocked;
  logic [TID_W-1:0] fetch_tid;
`ifdef MT_HAZARD_STATS_EN
  logic [31:0] switch_count, idle_cycles;
`endif

  mt_hazard_controller #(.THREADS(THREADS), .TID_W(TID_W), .SWITCH_PENALTY(PEN)) dut (
    .clk(clk), .rst_n(rst_n), .ic_miss(ic_miss), .load_use(load_use),
    .mispredict(mispredict), .mispredict_tid(mispredict_tid),
    .dc_miss(dc_miss), .dc_miss_tid(dc_miss_tid), .dc_fill(dc_fill), .dc_fill_tid(dc_fill_tid),
    .if_stall(if_stall), .if_flush(if_flush), .i2d_stall(i2d_stall), .i2d_flush(i2d_flush),
    .d2e_stall(d2e_stall), .d2e_flush(d2e_flush), .e2m_stall(e2m_stall), .e2m_flush(e2m_flush),
    .m2w_stall(m2w_stall), .m2w_flush(m2w_flush), .fetch_tid(fetch_tid),
    .thread_switch(thread_switch), .all_blocked(all_blocked)
`ifdef MT_HAZARD_STATS_EN
    , .switch_count(switch_count), .idle_cycles(idle_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] ctl;
    int         tid;
    bit         ts;
    bit         ab;
  } exp_t;

  exp_t q[$];
  int n_checks = 0, n_pass = 0;

  // reference model: thread mode, readiness table, cycles left in the switch window
  localparam int M_RUN = 0, M_SW = 1, M_IDLE = 2;
  int mmode, mtid, mremain;
  bit mblk[THREADS];
  int mswc, midle;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    mmode = M_RUN; mtid = 0; mremain = 0; mswc = 0; midle = 0;
    for (int i = 0; i < THREADS; i++) mblk[i] = 0;
  endtask

  task automatic step(input bit ic, input bit lu, input bit mp, input int mpt,
                      input bit dm, input int dmt, input bit df, input int dft);
    exp_t e;
    bit found;
    int start, t;
    e.ctl = C_NONE; e.tid = mtid; e.ts = 0; e.ab = (mmode == M_IDLE);
    if (mmode == M_IDLE) midle++;
    if (df) mblk[dft] = 0;
    if (dm) mblk[dmt] = 1;
    case (mmode)
      M_RUN: begin
        if (dm && dmt == mtid) begin
          e.ctl = C_ALLF;
          found = 0;
          start = mtid;
          for (int k = 1; k < THREADS; k++) begin
            t = (start + k) % THREADS;
            if (!found && !mblk[t]) begin found = 1; mtid = t; end
          end
          if (found) begin e.ts = 1; mmode = M_SW; mremain = PEN; end
          else mmode = M_IDLE;
        end else if (mp && mpt == mtid) e.ctl = C_MP;
        else if (lu) e.ctl = C_LU;
        else if (ic) e.ctl = C_IC;
      end
      M_SW: begin
        e.ctl = C_SW;
        mremain--;
        if (mremain == 0) mmode = M_RUN;
      end
      default: begin
        e.ctl = C_IDLE;
        if (df) begin mtid = dft; e.ts = 1; mmode = M_SW; mremain = PEN; end
      end
    endcase
    if (e.ts) mswc++;
    q.push_back(e);
  endtask

  task automatic cyc(input bit ic, input bit lu, input bit mp, input int mpt,
                     input bit dm, input int dmt, input bit df, input int dft);
    @(posedge clk);
    #1;
    rst_n = 1;
    ic_miss = ic; load_use = lu; mispredict = mp; mispredict_tid = TID_W'(mpt);
    dc_miss = dm; dc_miss_tid = TID_W'(dmt); dc_fill = df; dc_fill_tid = TID_W'(dft);
    step(ic, lu, mp, mpt, dm, dmt, df, dft);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rst_cycle();
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 0;
    ic_miss = 0; load_use = 0; mispredict = 0; dc_miss = 0; dc_fill = 0;
    e.ctl = C_ALLF; e.tid = 0; e.ts = 0; e.ab = 0;
    q.push_back(e);
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ctl", int'({if_stall, if_flush, i2d_stall, i2d_flush, d2e_stall, d2e_flush,
                           e2m_stall, e2m_flush, m2w_stall, m2w_flush}), int'(e.ctl));
        check("fetch_tid", int'(fetch_tid), e.tid);
        check("thread_switch", int'(thread_switch), int'(e.ts));
        check("all_blocked", int'(all_blocked), int'(e.ab));
      end
    end
  end

  initial begin : driver
    model_reset();
    rst_cycle();
    rst_cycle();
    // load-use bubble held three cycles
    cyc(0, 1, 0, 0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0, 0, 0);
    nop(1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    // miss on running thread 0 switches to thread 1
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    nop(3);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    // both threads miss -> IDLE, fill of thread 1 resumes it
    cyc(0, 0, 0, 0, 1, 1, 0, 0);
    nop(2);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    nop(3);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    nop(3);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    // miss and mispredict on the running thread together, then a stale mispredict
    cyc(0, 0, 1, 1, 1, 1, 0, 0);
    nop(3);
    cyc(0, 0, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    // same-cycle miss and fill for thread 1 keeps it blocked
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1, 1, 1);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    nop(2);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    nop(3);
    // reset in the middle of a switch window
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    rst_cycle();
    nop(2);
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom % 5) == 0, ($urandom % 4) == 0,
          ($urandom % 6) == 0, $urandom_range(0, THREADS - 1),
          ($urandom % 8) == 0, $urandom_range(0, THREADS - 1),
          ($urandom % 6) == 0, $urandom_range(0, THREADS - 1));
    end
    @(posedge clk);
    #1;
    check("queue_drained", q.size(), 0);
`ifdef MT_HAZARD_STATS_EN
    check("switch_count", int'(switch_count), mswc);
    check("idle_cycles", int'(idle_cycles), midle);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
